// File: rtl/seq_serializer.sv
// Parallel-in/serial-out feeder: WIDTH-bit words shifted out MSB-first, back-to-back with no gap.
// Optional even-parity bit after each word when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             last_bit;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign accept   = load_valid && load_ready;
  assign last_bit = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
          state_d = PAR;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      PAR: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready depends on state and counter only, never on load_valid
  always_comb begin
    load_ready = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE:  load_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      SHIFT: load_ready = 1'b0;
      PAR:   load_ready = 1'b1;
`else
      SHIFT: load_ready = last_bit;
`endif
      default: load_ready = 1'b0;
    endcase
  end

  // Datapath: a load always restarts the word from its MSB, whatever state it comes from
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    if (accept) begin
      sreg_d      = din << 1;
      out_d       = din[WIDTH-1];
      out_valid_d = 1'b1;
      cnt_d       = CW'(WIDTH - 1);
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_d       = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!last_bit) begin
            out_d       = sreg_q[WIDTH-1];
            sreg_d      = sreg_q << 1;
            cnt_d       = cnt_q - CW'(1);
            out_valid_d = 1'b1;
          end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
            out_d       = par_q;
            out_valid_d = 1'b1;
`else
            out_d       = 1'b0;
            out_valid_d = 1'b0;
`endif
          end
        end
        default: begin
          out_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: WIDTH=8 and WIDTH=2 instances against a word-level bit-stream model.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       lv8 = 1'b0, lv2 = 1'b0;
  logic [7:0] din8 = '0;
  logic [1:0] din2 = '0;
  logic       lr8, out8, ov8, busy8;
  logic       lr2, out2, ov2, busy2;

  seq_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .din(din8),
    .load_ready(lr8), .out(out8), .out_valid(ov8), .busy(busy8)
  );

  seq_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .din(din2),
    .load_ready(lr2), .out(out2), .out_valid(ov2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word becomes a sequence of bits (data MSB-first, then parity); one bit per cycle
  // is placed on the wire; a new word may be taken only when no bits of the current one remain.
  logic [32:0] m_seq [2];
  int          m_rem [2];
  logic        m_bit [2];
  logic        m_vld [2];

  always @(posedge clk or posedge rst) begin
    for (int id = 0; id < 2; id++) begin
      if (rst) begin
        m_rem[id] = 0;
        m_bit[id] = 1'b0;
        m_vld[id] = 1'b0;
        m_seq[id] = '0;
      end else begin
        logic        v;
        logic [31:0] w;
        int          wd;
        v  = (id == 0) ? lv8 : lv2;
        w  = (id == 0) ? {24'd0, din8} : {30'd0, din2};
        wd = (id == 0) ? 8 : 2;
        if (v && m_rem[id] == 0) begin
          if (PE != 0) begin
            m_seq[id] = {w, ^w};
            m_rem[id] = wd + 1;
          end else begin
            m_seq[id] = {1'b0, w};
            m_rem[id] = wd;
          end
        end
        if (m_rem[id] > 0) begin
          m_bit[id] = m_seq[id][m_rem[id]-1];
          m_vld[id] = 1'b1;
          m_rem[id] = m_rem[id] - 1;
        end else begin
          m_bit[id] = 1'b0;
          m_vld[id] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison plus stream capture, away from the active edge
  logic [63:0] cap8 = '0, cap2 = '0;
  int n8 = 0, n2 = 0, acc8 = 0, acc2 = 0, rdy8 = 0;

  always @(negedge clk) begin
    chk("out8",   {63'd0, out8},  {63'd0, m_bit[0]});
    chk("ov8",    {63'd0, ov8},   {63'd0, m_vld[0]});
    chk("busy8",  {63'd0, busy8}, {63'd0, m_vld[0]});
    chk("ready8", {63'd0, lr8},   {63'd0, m_rem[0] == 0});
    chk("out2",   {63'd0, out2},  {63'd0, m_bit[1]});
    chk("ov2",    {63'd0, ov2},   {63'd0, m_vld[1]});
    chk("busy2",  {63'd0, busy2}, {63'd0, m_vld[1]});
    chk("ready2", {63'd0, lr2},   {63'd0, m_rem[1] == 0});
    if (!rst) begin
      if (ov8) begin cap8 = {cap8[62:0], out8}; n8++; end
      if (ov2) begin cap2 = {cap2[62:0], out2}; n2++; end
      if (lv8 && lr8) acc8++;
      if (lv2 && lr2) acc2++;
      if (busy8 && lr8) rdy8++;
    end
  end

  int s_n8, s_acc8, s_rdy8, s_n2, s_acc2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    s_n8 = n8; s_acc8 = acc8; s_rdy8 = rdy8; s_n2 = n2; s_acc2 = acc2;
  endtask

  function automatic logic [63:0] low(input logic [63:0] v, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return v & m;
  endfunction

  task automatic send8(input logic [7:0] w);
    lv8 = 1'b1; din8 = w;
    step();
    lv8 = 1'b0;
  endtask

  task automatic b2b8(input logic [7:0] w0, input logic [7:0] w1);
    logic ok;
    ok = 1'b0;
    lv8 = 1'b1; din8 = w0;
    step();
    din8 = w1;
    for (int i = 0; i < 40; i++) begin
      if (lr8) begin step(); ok = 1'b1; break; end
      step();
    end
    lv8 = 1'b0;
    chk("b2b8_wait", {63'd0, ok}, 64'd1);
  endtask

  task automatic b2b2(input logic [1:0] w0, input logic [1:0] w1);
    logic ok;
    ok = 1'b0;
    lv2 = 1'b1; din2 = w0;
    step();
    din2 = w1;
    for (int i = 0; i < 20; i++) begin
      if (lr2) begin step(); ok = 1'b1; break; end
      step();
    end
    lv2 = 1'b0;
    chk("b2b2_wait", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    step(); step();
    chk("rst_ready", {63'd0, lr8}, 64'd1);
    chk("rst_out",   {63'd0, out8}, 64'd0);
    chk("rst_busy",  {63'd0, busy8}, 64'd0);
    rst = 1'b0;

    // Single word
    mark();
    send8(8'hB4);
    repeat (12) step();
    chk("single_n",    64'(n8 - s_n8), 64'(8 + PE));
    chk("single_bits", low(cap8, 8 + PE), (PE != 0) ? 64'h168 : 64'hB4);
    chk("single_acc",  64'(acc8 - s_acc8), 64'd1);
    chk("single_idle", {62'd0, busy8, ov8}, 64'd0);

    // Back-to-back with load_valid held
    mark();
    b2b8(8'hB0, 8'h2C);
    repeat (24) step();
    chk("b2b_n",    64'(n8 - s_n8), 64'(16 + 2 * PE));
    chk("b2b_bits", low(cap8, 16 + 2 * PE),
        (PE != 0) ? 64'({8'hB0, 1'b1, 8'h2C, 1'b1}) : 64'hB02C);
    chk("b2b_acc",  64'(acc8 - s_acc8), 64'd2);
    chk("b2b_rdy",  64'(rdy8 - s_rdy8), 64'd2);

    // Load pulse while busy is ignored
    mark();
    send8(8'h00);
    repeat (3) step();
    lv8 = 1'b1; din8 = 8'hFF;
    step();
    lv8 = 1'b0;
    repeat (12) step();
    chk("ign_n",    64'(n8 - s_n8), 64'(8 + PE));
    chk("ign_bits", low(cap8, 8 + PE), 64'd0);
    chk("ign_acc",  64'(acc8 - s_acc8), 64'd1);

    // Word whose parity is odd
    mark();
    send8(8'h01);
    repeat (12) step();
    chk("w01_bits", low(cap8, 8 + PE), (PE != 0) ? 64'h003 : 64'h01);

    // Async reset mid-word, then a fresh word
    send8(8'hA5);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("arst_out",   {63'd0, out8},  64'd0);
    chk("arst_ov",    {63'd0, ov8},   64'd0);
    chk("arst_busy",  {63'd0, busy8}, 64'd0);
    chk("arst_ready", {63'd0, lr8},   64'd1);
    step();
    rst = 1'b0;
    mark();
    send8(8'hC3);
    repeat (12) step();
    chk("post_rst_n",    64'(n8 - s_n8), 64'(8 + PE));
    chk("post_rst_bits", low(cap8, 8 + PE), (PE != 0) ? 64'h186 : 64'hC3);

    // WIDTH=2 back-to-back
    mark();
    b2b2(2'b10, 2'b11);
    repeat (8) step();
    chk("w2_n",    64'(n2 - s_n2), 64'(4 + 2 * PE));
    chk("w2_bits", low(cap2, 4 + 2 * PE), (PE != 0) ? 64'b101110 : 64'b1011);
    chk("w2_acc",  64'(acc2 - s_acc2), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
